cpu_bus_ctrl: RTL

CPU-side bus controller for the NES core, sitting directly downstream of the 6502 CPU bus (`cpu_addr_out`/`cpu_data_out`/`ren`/`wen`) and returning `cpu_data_in` and `rdy`. It decodes the CPU address map onto RAM, PPU registers, IO, cartridge SRAM and PRG ROM, and returns read data from synchronous-read memories. It also implements OAM DMA (write to $4014), stalling the CPU through `rdy` while it copies one 256-byte page to PPU register $2004.

---
 rtl/cpu_bus_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/cpu_bus_ctrl.sv
// CPU-side bus controller for the NES core: decodes the 6502 address map onto
// RAM/PPU/IO/SRAM/ROM, returns synchronous read data and runs OAM DMA from $4014.
module cpu_bus_ctrl (
    input  logic        clk,
    input  logic        b_rst,
    input  logic        syn_clk,
    input  logic [15:0] cpu_addr_out,
    input  logic [7:0]  cpu_data_out,
    input  logic        ren,
    input  logic        wen,
    output logic [7:0]  cpu_data_in,
    output logic        rdy,
    output logic [14:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        ram_cs,
    output logic        sram_cs,
    output logic        rom_cs,
    output logic        ppu_cs,
    output logic        io_cs,
    output logic        mem_we,
    input  logic [7:0]  ram_rdata,
    input  logic [7:0]  sram_rdata,
    input  logic [7:0]  rom_rdata,
    input  logic [7:0]  ppu_rdata,
    input  logic [7:0]  io_rdata
);

    typedef enum logic [2:0] {
        REG_NONE, REG_RAM, REG_PPU, REG_IO, REG_SRAM, REG_ROM
    } region_t;

    typedef enum logic [2:0] {
        ST_IDLE, ST_HALT, ST_ALIGN, ST_READ, ST_WRITE
    } dma_state_t;

    dma_state_t r_state;
    dma_state_t w_next_state;
    logic [7:0] r_page;
    logic [7:0] r_cnt;
    logic       r_parity;
    logic [7:0] r_dma_data;
    logic [7:0] r_cpu_data;
    region_t    r_tag;
    logic       r_tag_dma;

    logic [15:0] w_src_addr;
    region_t     w_region;
    logic [14:0] w_offset;
    region_t     w_rd_tag;
    logic [7:0]  w_rdata;
    logic        w_cpu_access;
    logic        w_cpu_write;
    logic        w_cpu_read;
    logic        w_dma_read;
    logic        w_dma_write;
    logic        w_dma_start;

    assign rdy         = (r_state == ST_IDLE);
    assign cpu_data_in = r_cpu_data;

    // Strobes are gated by reset so nothing reaches the memories while it is held.
    assign w_cpu_access = b_rst & syn_clk & (ren | wen) & rdy;
    assign w_cpu_write  = w_cpu_access & wen;
    assign w_cpu_read   = w_cpu_access & ~wen;
    assign w_dma_read   = b_rst & syn_clk & (r_state == ST_READ);
    assign w_dma_write  = b_rst & syn_clk & (r_state == ST_WRITE);
    assign w_dma_start  = w_cpu_write & (cpu_addr_out == 16'h4014);
    assign w_src_addr   = (r_state == ST_READ) ? {r_page, r_cnt} : cpu_addr_out;

    always_comb begin
        w_region = REG_NONE;
        w_offset = '0;
        if (w_src_addr[15]) begin
            w_region = REG_ROM;
            w_offset = w_src_addr[14:0];
        end else begin
            case (w_src_addr[14:13])
                2'b00: begin
                    w_region = REG_RAM;
                    w_offset = {4'b0, w_src_addr[10:0]};
                end
                2'b01: begin
                    w_region = REG_PPU;
                    w_offset = {12'b0, w_src_addr[2:0]};
                end
                2'b10: begin
                    if (w_src_addr[12:5] == 8'h00 && w_src_addr[4:0] != 5'h14) begin
                        w_region = REG_IO;
                        w_offset = {10'b0, w_src_addr[4:0]};
                    end
                end
                default: begin
                    w_region = REG_SRAM;
                    w_offset = {2'b0, w_src_addr[12:0]};
                end
            endcase
        end
    end

    // The DMA write to $2004 takes priority; otherwise the decoded source is strobed.
    always_comb begin
        ram_cs    = 1'b0;
        sram_cs   = 1'b0;
        rom_cs    = 1'b0;
        ppu_cs    = 1'b0;
        io_cs     = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = cpu_data_out;
        w_rd_tag  = REG_NONE;
        if (w_dma_write) begin
            ppu_cs    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = 15'd4;
            mem_wdata = r_dma_data;
        end else if (w_cpu_read || w_cpu_write || w_dma_read) begin
            case (w_region)
                REG_RAM:  ram_cs  = 1'b1;
                REG_PPU:  ppu_cs  = 1'b1;
                REG_IO:   io_cs   = 1'b1;
                REG_SRAM: sram_cs = 1'b1;
                REG_ROM:  rom_cs  = ~w_cpu_write;
                default:  ;
            endcase
            if (w_region != REG_NONE && !(w_region == REG_ROM && w_cpu_write)) begin
                mem_addr = w_offset;
                mem_we   = w_cpu_write;
                if (!w_cpu_write) w_rd_tag = w_region;
            end
        end
    end

    always_comb begin
        case (r_tag)
            REG_RAM:  w_rdata = ram_rdata;
            REG_PPU:  w_rdata = ppu_rdata;
            REG_IO:   w_rdata = io_rdata;
            REG_SRAM: w_rdata = sram_rdata;
            REG_ROM:  w_rdata = rom_rdata;
            default:  w_rdata = 8'h00;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_dma_start) w_next_state = ST_HALT;
            ST_HALT:  if (syn_clk) w_next_state = r_parity ? ST_ALIGN : ST_READ;
            ST_ALIGN: if (syn_clk) w_next_state = ST_READ;
            ST_READ:  if (syn_clk) w_next_state = ST_WRITE;
            ST_WRITE: if (syn_clk) w_next_state = (r_cnt == 8'hFF) ? ST_IDLE : ST_READ;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge b_rst) begin
        if (!b_rst) begin
            r_state    <= ST_IDLE;
            r_page     <= 8'h00;
            r_cnt      <= 8'h00;
            r_parity   <= 1'b0;
            r_dma_data <= 8'h00;
            r_cpu_data <= 8'h00;
            r_tag      <= REG_NONE;
            r_tag_dma  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (syn_clk) r_parity <= ~r_parity;
            if (w_dma_start) begin
                r_page <= cpu_data_out;
                r_cnt  <= 8'h00;
            end else if (w_dma_write) begin
                r_cnt <= r_cnt + 8'd1;
            end
            // Tag lives one clk so the memory's registered data is taken exactly once.
            r_tag     <= w_rd_tag;
            r_tag_dma <= w_dma_read;
            if (r_tag != REG_NONE) begin
                if (r_tag_dma) r_dma_data <= w_rdata;
                else           r_cpu_data <= w_rdata;
            end
        end
    end

endmodule
